// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the decode-stage control logic.
//   - Opcode constants used by the hazard / stall controller.
//   - Hazard controller state encoding (RUN / HOLD).
package rv32i_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } hz_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, clears the count
//   inc   : increment request for this cycle
//   count : current count; sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/id_hazard_stall_unit.sv
// Decode-stage hazard and stall controller.
// Detects dependencies that ID-stage forwarding cannot cover, stalls PC and
// IF/ID while bubbling ID/EX (one or two cycles), flushes IF/ID on a taken
// branch, and keeps saturating stall / flush event counters.
//   Inputs : ID opcode and rs1/rs2, branch result, EX and MEM producer info
//   Outputs: PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush (combinational),
//            StallCount, FlushCount (registered, saturating)
module id_hazard_stall_unit
    import rv32i_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       ID_opcode,
    input  logic [4:0]       ID_ReadRegNum1,
    input  logic [4:0]       ID_ReadRegNum2,
    input  logic             ID_BranchTaken,
    input  logic             EX_cntl_RegWrite,
    input  logic             EX_cntl_MemRead,
    input  logic [4:0]       EX_WriteRegNum,
    input  logic             MEM_cntl_MemRead,
    input  logic [4:0]       MEM_WriteRegNum,
    output logic             PCWrite,
    output logic             IFID_Write,
    output logic             IDEX_Bubble,
    output logic             IFID_Flush,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    hz_state_e state_q;
    hz_state_e state_d;

    logic       is_branch;
    logic       rs1_live;
    logic       rs2_live;
    logic       ex_match;
    logic       mem_match;
    logic [1:0] need;
    logic       stall;
    logic       flush;

    // A source only counts when the opcode actually reads it and it is not x0.
    always_comb begin
        is_branch = (ID_opcode == OP_BRANCH);
        rs1_live  = !((ID_opcode == OP_LUI) || (ID_opcode == OP_AUIPC) ||
                      (ID_opcode == OP_JAL)) && (ID_ReadRegNum1 != 5'd0);
        rs2_live  = ((ID_opcode == OP_BRANCH) || (ID_opcode == OP_STORE) ||
                     (ID_opcode == OP_RTYPE)) && (ID_ReadRegNum2 != 5'd0);

        ex_match  = EX_cntl_RegWrite && (EX_WriteRegNum != 5'd0) &&
                    ((rs1_live && (EX_WriteRegNum == ID_ReadRegNum1)) ||
                     (rs2_live && (EX_WriteRegNum == ID_ReadRegNum2)));
        mem_match = MEM_cntl_MemRead && (MEM_WriteRegNum != 5'd0) &&
                    ((rs1_live && (MEM_WriteRegNum == ID_ReadRegNum1)) ||
                     (rs2_live && (MEM_WriteRegNum == ID_ReadRegNum2)));
    end

    // Priority order picks the larger need when EX and MEM both match.
    always_comb begin
        need = 2'd0;
        if (state_q == RUN) begin
            if (is_branch && ex_match && EX_cntl_MemRead) begin
                need = 2'd2;
            end else if (is_branch && ex_match) begin
                need = 2'd1;
            end else if (is_branch && mem_match) begin
                need = 2'd1;
            end else if (!is_branch && ex_match && EX_cntl_MemRead) begin
                need = 2'd1;
            end
        end
    end

    // Stall beats flush: branch operands are not valid on a stall cycle.
    always_comb begin
        stall = !rst && ((state_q == HOLD) || (need != 2'd0));
        flush = !rst && (state_q == RUN) && (need == 2'd0) && ID_BranchTaken;

        PCWrite     = !stall;
        IFID_Write  = !stall;
        IDEX_Bubble = stall;
        IFID_Flush  = flush;
    end

    always_comb begin
        state_d = RUN;
        if ((state_q == RUN) && (need == 2'd2)) begin
            state_d = HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall),
        .count (StallCount)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush),
        .count (FlushCount)
    );

endmodule

// File: tb/tb_id_hazard_stall_unit.sv
module tb_id_hazard_stall_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  ID_opcode;
    logic [4:0]  ID_ReadRegNum1;
    logic [4:0]  ID_ReadRegNum2;
    logic        ID_BranchTaken;
    logic        EX_cntl_RegWrite;
    logic        EX_cntl_MemRead;
    logic [4:0]  EX_WriteRegNum;
    logic        MEM_cntl_MemRead;
    logic [4:0]  MEM_WriteRegNum;

    logic        PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush;
    logic [15:0] StallCount, FlushCount;
    logic        s_PCWrite, s_IFID_Write, s_IDEX_Bubble, s_IFID_Flush;
    logic [1:0]  s_StallCount, s_FlushCount;

    int unsigned errors = 0;
    int unsigned checks = 0;

    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] LUI = 7'b0110111;
    localparam logic [6:0] IMM = 7'b0010011;

    // {PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush}
    localparam logic [3:0] O_RUN   = 4'b1100;
    localparam logic [3:0] O_STALL = 4'b0010;
    localparam logic [3:0] O_FLUSH = 4'b1101;

    always #5 clk = ~clk;

    id_hazard_stall_unit #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .ID_opcode(ID_opcode), .ID_ReadRegNum1(ID_ReadRegNum1),
        .ID_ReadRegNum2(ID_ReadRegNum2), .ID_BranchTaken(ID_BranchTaken),
        .EX_cntl_RegWrite(EX_cntl_RegWrite), .EX_cntl_MemRead(EX_cntl_MemRead),
        .EX_WriteRegNum(EX_WriteRegNum), .MEM_cntl_MemRead(MEM_cntl_MemRead),
        .MEM_WriteRegNum(MEM_WriteRegNum),
        .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IDEX_Bubble(IDEX_Bubble),
        .IFID_Flush(IFID_Flush), .StallCount(StallCount), .FlushCount(FlushCount)
    );

    id_hazard_stall_unit #(.CNT_W(2)) dut_small (
        .clk(clk), .rst(rst),
        .ID_opcode(ID_opcode), .ID_ReadRegNum1(ID_ReadRegNum1),
        .ID_ReadRegNum2(ID_ReadRegNum2), .ID_BranchTaken(ID_BranchTaken),
        .EX_cntl_RegWrite(EX_cntl_RegWrite), .EX_cntl_MemRead(EX_cntl_MemRead),
        .EX_WriteRegNum(EX_WriteRegNum), .MEM_cntl_MemRead(MEM_cntl_MemRead),
        .MEM_WriteRegNum(MEM_WriteRegNum),
        .PCWrite(s_PCWrite), .IFID_Write(s_IFID_Write), .IDEX_Bubble(s_IDEX_Bubble),
        .IFID_Flush(s_IFID_Flush), .StallCount(s_StallCount), .FlushCount(s_FlushCount)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_o(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush}, {28'd0, exp});
    endtask

    // ID: opcode, rs1, rs2, taken | EX: regwrite, memread, rd | MEM: memread, rd
    task automatic set_in(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                          input logic tk, input logic exw, input logic exm, input logic [4:0] exd,
                          input logic mm, input logic [4:0] md);
        ID_opcode = op; ID_ReadRegNum1 = r1; ID_ReadRegNum2 = r2; ID_BranchTaken = tk;
        EX_cntl_RegWrite = exw; EX_cntl_MemRead = exm; EX_WriteRegNum = exd;
        MEM_cntl_MemRead = mm; MEM_WriteRegNum = md;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with a load-to-branch hazard present: must not stall or count
        rst = 1'b1;
        set_in(BR, 5'd6, 5'd7, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0, 5'd0);
        chk_o("rst_outputs", O_RUN);
        step();
        chk_o("rst_outputs_after_edge", O_RUN);
        chk("rst_stallcnt", StallCount, 0);
        chk("rst_flushcnt", FlushCount, 0);
        rst = 1'b0;

        // Idle: addi x0,x0,0
        set_in(IMM, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        chk_o("idle", O_RUN);
        step();

        // ALU-to-branch: EX addi x5, ID beq x5,x0 -> one stall
        set_in(BR, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 5'd5, 1'b0, 5'd0);
        chk_o("alu_br_stall", O_STALL);
        step();
        set_in(BR, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd5);
        chk_o("alu_br_resume", O_RUN);
        chk("alu_br_cnt", StallCount, 1);
        chk("alu_br_cnt_small", {30'd0, s_StallCount}, 1);

        // Load-to-branch: EX lw x6, ID bne x6,x7 -> RUN stall then HOLD stall
        set_in(BR, 5'd6, 5'd7, 1'b0, 1'b1, 1'b1, 5'd6, 1'b0, 5'd0);
        chk_o("ld_br_stall1", O_STALL);
        step();
        // HOLD ignores hazards and a taken branch
        set_in(BR, 5'd6, 5'd7, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd6);
        chk_o("ld_br_stall2_hold", O_STALL);
        step();
        set_in(BR, 5'd6, 5'd7, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        chk_o("ld_br_resume", O_RUN);
        chk("ld_br_cnt", StallCount, 3);
        chk("ld_br_flushcnt", FlushCount, 0);

        // Load-use: EX lw x8, ID add x9,x8,x1
        set_in(RT, 5'd8, 5'd1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0);
        chk_o("ld_use_stall", O_STALL);
        step();
        chk("ld_use_cnt", StallCount, 4);
        // EX lw x0 against add x9,x0,x1: x0 never hazards
        set_in(RT, 5'd0, 5'd1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0);
        chk_o("ld_x0_nostall", O_RUN);

        // lui does not read its register fields
        set_in(LUI, 5'd3, 5'd3, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 5'd0);
        chk_o("lui_nostall", O_RUN);
        step();
        // sw x3,0(x4): rs2 = x3 is read
        set_in(ST, 5'd4, 5'd3, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 5'd0);
        chk_o("sw_rs2_stall", O_STALL);
        step();
        chk("sw_cnt", StallCount, 5);
        chk("sat_small_stall", {30'd0, s_StallCount}, 3);

        // Taken branch without hazard -> single flush
        set_in(BR, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        chk_o("taken_flush", O_FLUSH);
        step();
        chk("flush_cnt", FlushCount, 1);
        set_in(IMM, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        chk_o("after_flush", O_RUN);
        step();

        // Taken branch during a stall -> no flush
        set_in(BR, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 5'd5, 1'b0, 5'd0);
        chk_o("taken_in_stall", O_STALL);
        step();
        chk("stall_cnt6", StallCount, 6);
        chk("flush_cnt_hold", FlushCount, 1);

        // MEM load feeding a branch -> one stall
        set_in(BR, 5'd10, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd10);
        chk_o("mem_br_stall", O_STALL);
        step();

        // EX ALU x11 and MEM lw x12 on beq x11,x12 -> need 1 only, no HOLD
        set_in(BR, 5'd11, 5'd12, 1'b0, 1'b1, 1'b0, 5'd11, 1'b1, 5'd12);
        chk_o("both_match_stall", O_STALL);
        step();
        set_in(BR, 5'd11, 5'd12, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd11);
        chk_o("both_match_resume", O_RUN);
        chk("stall_cnt8", StallCount, 8);

        // Reset asserted in HOLD
        set_in(BR, 5'd6, 5'd7, 1'b0, 1'b1, 1'b1, 5'd6, 1'b0, 5'd0);
        chk_o("hold_rst_stall1", O_STALL);
        step();
        rst = 1'b1;
        set_in(BR, 5'd6, 5'd7, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0, 5'd0);
        chk_o("rst_in_hold_outputs", O_RUN);
        step();
        rst = 1'b0;
        set_in(IMM, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        chk_o("no_residual_hold", O_RUN);
        chk("rst_hold_stallcnt", StallCount, 0);
        chk("rst_hold_flushcnt", FlushCount, 0);
        chk("rst_hold_small_cnt", {30'd0, s_StallCount}, 0);
        step();
        chk("idle_cnt_stays0", StallCount, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_hazard_stall_unit.md
# id_hazard_stall_unit

Decode-stage hazard and stall controller for the pipelined RV32I core. It is the counterpart of the ID-stage branch forwarding logic: it detects the dependencies that forwarding cannot resolve in time, holds PC and IF/ID, and injects ID/EX bubbles for one or two cycles. It flushes IF/ID on a resolved taken branch and keeps saturating stall and flush event counters for performance debug.

## Interface
Parameters:
- CNT_W, 16, width of the StallCount and FlushCount counters.

Ports (clock is `clk`; reset is `rst`, synchronous, active-high):
- clk  input  1  core clock; all state updates on the rising edge
- rst  input  1  synchronous active-high reset
- ID_opcode  input  7  opcode of the instruction in ID
- ID_ReadRegNum1  input  5  rs1 of the ID instruction
- ID_ReadRegNum2  input  5  rs2 of the ID instruction
- ID_BranchTaken  input  1  branch comparator result in ID, after forwarding
- EX_cntl_RegWrite  input  1  EX instruction writes the register file
- EX_cntl_MemRead  input  1  EX instruction is a load
- EX_WriteRegNum  input  5  rd of the EX instruction
- MEM_cntl_MemRead  input  1  MEM instruction is a load
- MEM_WriteRegNum  input  5  rd of the MEM instruction
- PCWrite  output  1  1 = PC may advance
- IFID_Write  output  1  1 = IF/ID may load
- IDEX_Bubble  output  1  1 = zero the ID/EX control fields this cycle
- IFID_Flush  output  1  1 = clear IF/ID on the next edge
- StallCount  output  CNT_W  number of stall cycles, saturating
- FlushCount  output  CNT_W  number of flushes, saturating

## Operation
- Register usage:
  - rs1 is used by every opcode except LUI 0110111, AUIPC 0010111 and JAL 1101111.
  - rs2 is used only by branch 1100011, store 0100011 and R-type 0110011.
  - A register number of 0 never causes a hazard.
- Match terms:
  - EXm: EX_cntl_RegWrite, EX_WriteRegNum != 0, and EX_WriteRegNum equals a used rs.
  - MEMm: MEM_cntl_MemRead, MEM_WriteRegNum != 0, and MEM_WriteRegNum equals a used rs.
- Stall need, evaluated only in state RUN:
  - Branch in ID with EXm and EX_cntl_MemRead: need = 2.
  - Else branch in ID with EXm (ALU producer): need = 1.
  - Else branch in ID with MEMm: need = 1.
  - Else non-branch with EXm and EX_cntl_MemRead (load-use): need = 1.
  - Else need = 0.
- FSM states:
  - RUN: if need = 2, stall and go to HOLD. If need = 1, stall and stay in RUN; the bubble clears the condition. If need = 0, stay in RUN.
  - HOLD: stall unconditionally, ignore all hazard inputs, go to RUN.
- Stall cycle outputs: PCWrite = 0, IFID_Write = 0, IDEX_Bubble = 1, IFID_Flush = 0.
- Flush: IFID_Flush = 1 only in RUN, with need = 0 and ID_BranchTaken = 1.
  - A stall has priority over a flush, because branch operands are not yet valid.
  - ID_BranchTaken is ignored in HOLD and on any stall cycle.
- Non-stall cycle outputs: PCWrite = 1, IFID_Write = 1, IDEX_Bubble = 0.
- Counters:
  - StallCount increments on every cycle with IDEX_Bubble = 1.
  - FlushCount increments on every cycle with IFID_Flush = 1.
  - Both saturate at 2^CNT_W - 1 and do not wrap.

## Timing
- All outputs except the counters are combinational from the current state and inputs, so they take effect in the same cycle.
- The state register and both counters are registered.
- Latency: an ALU-to-branch dependency costs 1 cycle; a load-to-branch dependency costs 2 cycles; a load-use dependency costs 1 cycle.
- Reset values: state = RUN, StallCount = 0, FlushCount = 0.
- While rst = 1: PCWrite = 1, IFID_Write = 1, IDEX_Bubble = 0, IFID_Flush = 0, and neither counter increments.
- Reset asserted in HOLD returns the block to RUN on that edge; no residual stall cycle follows.
- Simultaneous EXm and MEMm on a branch resolve to the larger need.

## Structure
- Shared package `rv32i_pkg` holds:
  - opcode constants: OP_BRANCH, OP_STORE, OP_RTYPE, OP_LUI, OP_AUIPC, OP_JAL;
  - the state enum RUN/HOLD.
- Sub-module `sat_counter` (parameter W; ports clk, rst, inc, count) is instantiated twice, once per counter.
- The rs-usage decode and the need computation stay inline.

## Test plan
- ALU-to-branch: EX addi writing x5, ID beq x5,x0 -> exactly 1 cycle with PCWrite = 0 and IDEX_Bubble = 1, then RUN; StallCount = 1.
- Load-to-branch: EX lw x6, ID bne x6,x7 -> 2 consecutive stall cycles (RUN then HOLD), state back to RUN; StallCount = 2.
- Load-use: EX lw x8, ID add x9,x8,x1 -> 1 stall. Repeat with EX lw x0 -> no stall.
- rs2-usage check: EX lw x3, ID lui x3 -> no stall. EX lw x3, ID sw x3,0(x4) -> 1 stall.
- Taken branch: ID beq with no hazard and ID_BranchTaken = 1 -> IFID_Flush = 1 for 1 cycle; FlushCount = 1. With ID_BranchTaken = 1 during a stall -> IFID_Flush = 0.
- Reset and saturation:
  - rst asserted in HOLD -> RUN next cycle, outputs non-stalling, counters 0.
  - With CNT_W = 2, drive 5 stall cycles -> StallCount = 3.
